multiport_regfile: RTL and testbench
====================================

MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits (multiple of 8).
REQ-002 Parameter DEPTH, default 32, number of entries (power of two, >=4); ADDR_W = clog2(DEPTH).
REQ-003 Parameter NRD, default 2, number of read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, entry 0 reads 0 and ignores writes when 1.
REQ-005 Parameter BYPASS, default 1, write-to-read forwarding enabled when 1.
REQ-006 Parameter INIT_MODE, default 1, initialisation value: 0 = all zero, 1 = entry i holds i.
REQ-007 clk  in  1  single clock; all state changes on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 clr  in  1  synchronous pulse requesting re-initialisation of the whole array.
REQ-010 we  in  1  write enable.
REQ-011 wa  in  ADDR_W  write address.
REQ-012 wbe  in  DATA_W/8  byte write enables.
REQ-013 wd  in  DATA_W  write data.
REQ-014 ra  in  NRD x ADDR_W  read addresses, one per port.
REQ-015 rd  out  NRD x DATA_W  read data, one per port.
REQ-016 probe_idx  in  ADDR_W  debug probe address.
REQ-017 probe_data  out  DATA_W  debug probe data, never bypassed.
REQ-018 ready  out  1  high when array is initialised and accepting writes.

Function
REQ-019 Reads combinational: rd[p] = array[ra[p]] the same cycle; probe_data = array[probe_idx].
REQ-020 Write on rising edge when we && ready: byte k of array[wa] takes wd byte k only where wbe[k]=1.
REQ-021 ZERO_REG=1: rd/probe for address 0 return 0; writes to address 0 have no effect.
REQ-022 BYPASS=1: when we && ready && wa==ra[p] (and not suppressed by REQ-021), rd[p] returns the byte-merged new value (wbe bytes from wd, rest from array) in the same cycle.
REQ-023 BYPASS=0: rd returns the pre-write value; new value visible the cycle after the edge.
REQ-024 FSM states: INIT, READY.
REQ-025 INIT: counter idx walks 0..DEPTH-1, writing init value (REQ-006) to array[idx] one entry per cycle; ready=0.
REQ-026 INIT -> READY on the edge that writes entry DEPTH-1; initialisation takes exactly DEPTH cycles.
REQ-027 READY -> INIT when clr=1; idx restarts at 0; a write presented in that same cycle is dropped.
REQ-028 clr asserted during INIT restarts idx at 0.
REQ-029 we while ready=0 is ignored; no bypass.
REQ-030 During INIT, rd and probe_data return 0.
REQ-031 Address values >= DEPTH cannot occur (power-of-two depth); no range check.

Reset
REQ-032 rst asserted: state=INIT, idx=0, ready=0 immediately (asynchronous).
REQ-033 Array storage is not reset; it is filled by the INIT walk after rst deasserts.
REQ-034 rst mid-INIT or mid-write aborts; the walk restarts from 0 after deassertion.

Structure
REQ-035 Shared package holds the state enum (INIT, READY) and the INIT_MODE encoding constants.
REQ-036 Single module, no sub-module; read-port logic generated per port by loop over NRD.

Verification
REQ-037 Reset, DEPTH=32, INIT_MODE=1: ready rises after exactly 32 cycles; probe_idx=5 -> probe_data=5, probe_idx=0 -> 0.
REQ-038 Write wa=7, wd=0xDEADBEEF, wbe=0b0011, ra[0]=7, BYPASS=1: rd[0]=0x0000BEEF same cycle (prior value 7 => 0x0000BEEF); probe next cycle = 0x0000BEEF.
REQ-039 Write wa=0, wd=0xFFFFFFFF, ZERO_REG=1: rd for ra=0 stays 0 before and after the edge.
REQ-040 BYPASS=0, write wa=3, wd=0x12345678, wbe=0xF, ra[1]=3: rd[1]=3 that cycle, 0x12345678 next.
REQ-041 clr pulse with we=1 (wa=9, wd=0xAA) in READY: write dropped, ready=0 for 32 cycles, then entry 9 reads 9.
REQ-042 rst asserted at INIT cycle 10: ready stays 0, walk restarts; ready rises 32 cycles after deassertion.

Source files
------------

// File: rtl/multiport_regfile_pkg.sv
// Shared types and constants for the multiport register file.
// Holds the init/ready state encoding and the init-value selector codes.
package multiport_regfile_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } rf_state_e;

    localparam int INIT_ZERO  = 0;
    localparam int INIT_INDEX = 1;

endpackage

// File: rtl/multiport_regfile.sv
// Multiport register file: NRD combinational read ports, one byte-masked write
// port, optional zero register and write-to-read forwarding, self-initialising array.
module multiport_regfile
    import multiport_regfile_pkg::*;
#(
    parameter int  DATA_W    = 32,
    parameter int  DEPTH     = 32,
    parameter int  NRD       = 2,
    parameter bit  ZERO_REG  = 1'b1,
    parameter bit  BYPASS    = 1'b1,
    parameter int  INIT_MODE = INIT_INDEX,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int NBYTES    = DATA_W / 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic                    we_i,
    input  logic [ADDR_W-1:0]       wa_i,
    input  logic [NBYTES-1:0]       wbe_i,
    input  logic [DATA_W-1:0]       wd_i,
    input  logic [NRD*ADDR_W-1:0]   ra_i,
    output logic [NRD*DATA_W-1:0]   rd_o,
    input  logic [ADDR_W-1:0]       probe_idx_i,
    output logic [DATA_W-1:0]       probe_data_o,
    output logic                    ready_o
);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              init_we;
    logic [DATA_W-1:0] init_val;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              ready;
    logic              wr_fire;
    logic [DATA_W-1:0] wr_merged;

    assign ready   = (state_q == ST_READY);
    assign ready_o = ready;

    // clr wins over a same-cycle write; address 0 is read-only when ZERO_REG is set
    assign wr_fire = ready && we_i && !clr_i && !(ZERO_REG && (wa_i == '0));

    always_comb begin
        wr_merged = mem_q[wa_i];
        for (int k = 0; k < NBYTES; k++) begin
            if (wbe_i[k]) wr_merged[8*k +: 8] = wd_i[8*k +: 8];
        end
    end

    assign init_val = (INIT_MODE == INIT_INDEX) ? DATA_W'(idx_q) : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        init_we = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (clr_i) begin
                    idx_d = '0;
                end else begin
                    init_we = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == ADDR_W'(DEPTH - 1)) state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (clr_i) begin
                    state_d = ST_INIT;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                idx_d   = '0;
            end
        endcase
    end

    // Storage has no reset; the init walk fills it after rst drops
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (init_we) begin
                mem_q[idx_q] <= init_val;
            end else if (wr_fire) begin
                mem_q[wa_i] <= wr_merged;
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] val;

        assign addr = ra_i[p*ADDR_W +: ADDR_W];

        always_comb begin
            val = mem_q[addr];
            if (BYPASS && wr_fire && (wa_i == addr)) val = wr_merged;
            if (!ready || (ZERO_REG && (addr == '0))) val = '0;
        end

        assign rd_o[p*DATA_W +: DATA_W] = val;
    end

    always_comb begin
        probe_data_o = mem_q[probe_idx_i];
        if (!ready || (ZERO_REG && (probe_idx_i == '0))) probe_data_o = '0;
    end

endmodule

// File: tb/tb_multiport_regfile.sv
// Self-checking bench for multiport_regfile: a bypassing and a non-bypassing
// instance share stimulus and are compared against an array-level reference model.
module tb_multiport_regfile;

    localparam int DW = 32;
    localparam int DP = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic             clk = 1'b0;
    logic             rst, clr, we;
    logic [AW-1:0]    wa, probe_idx;
    logic [DW/8-1:0]  wbe;
    logic [DW-1:0]    wd;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd_b, rd_n;
    logic [DW-1:0]    probe_b, probe_n;
    logic             ready_b, ready_n;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mdl [DP];
    bit            mready;
    int            mcnt;

    always #5 clk = ~clk;

    multiport_regfile #(.BYPASS(1'b1)) u_byp (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .we_i(we), .wa_i(wa), .wbe_i(wbe),
        .wd_i(wd), .ra_i(ra), .rd_o(rd_b), .probe_idx_i(probe_idx),
        .probe_data_o(probe_b), .ready_o(ready_b)
    );

    multiport_regfile #(.BYPASS(1'b0)) u_nbyp (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .we_i(we), .wa_i(wa), .wbe_i(wbe),
        .wd_i(wd), .ra_i(ra), .rd_o(rd_n), .probe_idx_i(probe_idx),
        .probe_data_o(probe_n), .ready_o(ready_n)
    );

    function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d,
                                            logic [DW/8-1:0] be);
        logic [DW-1:0] o = old;
        for (int k = 0; k < DW/8; k++) if (be[k]) o[8*k +: 8] = d[8*k +: 8];
        return o;
    endfunction

    function automatic logic [DW-1:0] exp_rd(logic [AW-1:0] a, bit byp);
        if (!mready || a == 0) return '0;
        if (byp && we && !clr && wa == a) return merge(mdl[a], wd, wbe);
        return mdl[a];
    endfunction

    // Advance one clock and apply the edge's effect to the model
    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            mready = 0; mcnt = 0;
        end else if (!mready) begin
            if (clr) mcnt = 0;
            else begin
                mcnt++;
                if (mcnt == DP) begin
                    for (int i = 0; i < DP; i++) mdl[i] = DW'(i);
                    mready = 1;
                end
            end
        end else if (clr) begin
            mready = 0; mcnt = 0;
        end else if (we && wa != 0) begin
            mdl[wa] = merge(mdl[wa], wd, wbe);
        end
        #1;
    endtask

    task automatic test_reset();
        int rise = -1;
        rst = 1; clr = 0; we = 0; wa = 0; wbe = 0; wd = 0; ra = 0; probe_idx = 5;
        #3;
        checks++;
        if (ready_b !== 1'b0 || ready_n !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b/%b want 0", ready_b, ready_n);
        end
        cyc(); cyc();
        rst = 0;
        for (int n = 1; n <= 40; n++) begin
            cyc();
            if (ready_b && rise < 0) rise = n;
            checks++;
            if (ready_b !== mready || ready_n !== mready) begin
                errors++; $display("FAIL init_ready n=%0d got %b/%b want %b", n, ready_b, ready_n, mready);
            end
            if (!mready) begin
                checks++;
                if (probe_b !== 0 || rd_b !== 0) begin
                    errors++; $display("FAIL init_zero n=%0d probe %h rd %h want 0", n, probe_b, rd_b);
                end
            end
        end
        checks++;
        if (rise != 32) begin errors++; $display("FAIL init_len got %0d want 32", rise); end
        probe_idx = 5; #1;
        checks++;
        if (probe_b !== 32'd5) begin errors++; $display("FAIL probe5 got %h want 5", probe_b); end
        probe_idx = 0; #1;
        checks++;
        if (probe_b !== 32'd0) begin errors++; $display("FAIL probe0 got %h want 0", probe_b); end
    endtask

    task automatic test_bypass_byte();
        ra = {5'd7, 5'd7}; wa = 7; wd = 32'hDEADBEEF; wbe = 4'b0011; we = 1; #1;
        checks++;
        if (rd_b[31:0] !== 32'h0000BEEF) begin
            errors++; $display("FAIL byp_same got %h want 0000beef", rd_b[31:0]);
        end
        checks++;
        if (rd_n[31:0] !== 32'h7) begin errors++; $display("FAIL nbyp_same got %h want 7", rd_n[31:0]); end
        cyc(); we = 0; probe_idx = 7; #1;
        checks++;
        if (probe_b !== 32'h0000BEEF || probe_n !== 32'h0000BEEF) begin
            errors++; $display("FAIL byp_probe got %h/%h want 0000beef", probe_b, probe_n);
        end
    endtask

    task automatic test_zero_reg();
        ra = '0; wa = 0; wd = 32'hFFFFFFFF; wbe = 4'hF; we = 1; #1;
        checks++;
        if (rd_b[31:0] !== 0) begin errors++; $display("FAIL zero_before got %h want 0", rd_b[31:0]); end
        cyc(); we = 0; probe_idx = 0; #1;
        checks++;
        if (rd_b[31:0] !== 0 || probe_b !== 0) begin
            errors++; $display("FAIL zero_after got %h/%h want 0", rd_b[31:0], probe_b);
        end
    endtask

    task automatic test_nobypass();
        ra = {5'd3, 5'd0}; wa = 3; wd = 32'h12345678; wbe = 4'hF; we = 1; #1;
        checks++;
        if (rd_n[63:32] !== 32'd3) begin errors++; $display("FAIL nbyp_old got %h want 3", rd_n[63:32]); end
        checks++;
        if (rd_b[63:32] !== 32'h12345678) begin
            errors++; $display("FAIL byp_new got %h want 12345678", rd_b[63:32]);
        end
        cyc(); we = 0; #1;
        checks++;
        if (rd_n[63:32] !== 32'h12345678) begin
            errors++; $display("FAIL nbyp_next got %h want 12345678", rd_n[63:32]);
        end
    endtask

    task automatic wait_init(string tag);
        for (int k = 0; k <= 34; k++) begin
            checks++;
            if (ready_b !== (k >= 32) || ready_n !== (k >= 32)) begin
                errors++; $display("FAIL %s_ready k=%0d got %b want %b", tag, k, ready_b, k >= 32);
            end
            cyc();
        end
        probe_idx = 9; #1;
        checks++;
        if (probe_b !== 32'd9 || probe_n !== 32'd9) begin
            errors++; $display("FAIL %s_e9 got %h/%h want 9", tag, probe_b, probe_n);
        end
    endtask

    task automatic test_clr_write();
        clr = 1; we = 1; wa = 9; wd = 32'hAA; wbe = 4'hF; ra = {5'd9, 5'd9}; #1;
        checks++;
        if (ready_b !== 1'b1 || rd_b[31:0] !== 32'd9) begin
            errors++; $display("FAIL clr_cycle ready %b rd %h want 1/9", ready_b, rd_b[31:0]);
        end
        cyc(); clr = 0; we = 0;
        wait_init("clr");
    endtask

    task automatic test_rst_mid_init();
        clr = 1; cyc(); clr = 0;
        repeat (10) cyc();
        #2 rst = 1; #1;
        checks++;
        if (ready_b !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", ready_b); end
        cyc(); rst = 0;
        wait_init("midrst");
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int it = 0; it < 400; it++) begin
            we = 1'($urandom); wa = AW'($urandom); wbe = 4'($urandom); wd = $urandom;
            ra = NR*AW'($urandom); probe_idx = AW'($urandom);
            if ($urandom_range(2) == 0) ra[AW-1:0] = wa;
            clr = ($urandom_range(59) == 0);
            #1;
            checks++;
            if (ready_b !== mready || ready_n !== mready) begin
                errors++; $display("FAIL rnd_ready it=%0d got %b/%b want %b", it, ready_b, ready_n, mready);
            end
            for (int p = 0; p < NR; p++) begin
                a = ra[p*AW +: AW];
                checks++;
                if (rd_b[p*DW +: DW] !== exp_rd(a, 1'b1) || rd_n[p*DW +: DW] !== exp_rd(a, 1'b0)) begin
                    errors++;
                    $display("FAIL rnd_rd it=%0d p=%0d a=%0d got %h/%h want %h/%h", it, p, a,
                             rd_b[p*DW +: DW], rd_n[p*DW +: DW], exp_rd(a, 1'b1), exp_rd(a, 1'b0));
                end
            end
            checks++;
            if (probe_b !== exp_rd(probe_idx, 1'b0) || probe_n !== exp_rd(probe_idx, 1'b0)) begin
                errors++; $display("FAIL rnd_probe it=%0d got %h/%h want %h", it, probe_b, probe_n,
                                   exp_rd(probe_idx, 1'b0));
            end
            cyc();
        end
        clr = 0; we = 0;
    endtask

    initial begin
        test_reset();
        test_bypass_byte();
        test_zero_reg();
        test_nobypass();
        test_clr_write();
        test_rst_mid_init();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
